// File: rtl/l2_fetch_arbiter.sv
// Round-robin arbiter sharing one L2 line-fetch port between NREQ L1 requesters.
// One outstanding L2 transaction at a time; the returned line goes to the granted requester only.
module l2_fetch_arbiter #(
    parameter int NREQ                    = 2,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56,
    parameter int LINE_WIDTH              = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NREQ-1:0]                         req,
    input  logic [NREQ*PHYSICAL_ADDRESS_LENGTH-1:0] req_addr,
    output logic [NREQ-1:0]                         req_done,
    output logic [LINE_WIDTH-1:0]                   req_data,
    output logic                                    l2_req,
    output logic [PHYSICAL_ADDRESS_LENGTH-1:0]      l2_addr,
    input  logic                                    l2_done,
    input  logic [LINE_WIDTH-1:0]                   l2_data,
    output logic [$clog2(NREQ)-1:0]                 grant_id,
    output logic                                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int PAL = PHYSICAL_ADDRESS_LENGTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic           found;
    logic [PAL-1:0] addr_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*PAL +: PAL];
        end
    end

    // Cyclic search starting just after the last winner; the last winner itself is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            l2_req   <= 1'b0;
            l2_addr  <= '0;
            req_done <= '0;
            req_data <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        l2_addr  <= addr_arr[winner];
                        grant_id <= winner;
                        ptr      <= winner;
                        l2_req   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (l2_done) begin
                        req_data <= l2_data;
                        req_done <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                        l2_req   <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // Extra cycle lets the completed requester drop req before the next arbitration.
                    req_done <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_fetch_arbiter.sv
// Randomized scoreboard bench for l2_fetch_arbiter: a transaction-level model predicts
// grants and completions; a negedge monitor pops and compares them against the DUT.
module tb_l2_fetch_arbiter;
    localparam int NREQ = 2;
    localparam int PAL  = 56;
    localparam int LW   = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*PAL-1:0]    req_addr;
    logic [NREQ-1:0]        req_done;
    logic [LW-1:0]          req_data;
    logic                   l2_req;
    logic [PAL-1:0]         l2_addr;
    logic                   l2_done;
    logic [LW-1:0]          l2_data;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                   busy;

    always #5 clk = ~clk;

    l2_fetch_arbiter #(
        .NREQ(NREQ),
        .PHYSICAL_ADDRESS_LENGTH(PAL),
        .LINE_WIDTH(LW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .req_done(req_done),
        .req_data(req_data),
        .l2_req(l2_req),
        .l2_addr(l2_addr),
        .l2_done(l2_done),
        .l2_data(l2_data),
        .grant_id(grant_id),
        .busy(busy)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] val;
    } ev_t;

    ev_t  gq[$];
    ev_t  dq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic exp_l2req = 1'b0;
    logic exp_busy  = 1'b0;
    logic mon_en    = 1'b0;
    logic l2_req_q  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: level checks every cycle, event checks when the DUT presents a grant or a done.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            chk("l2_req_level", 64'(l2_req), 64'(exp_l2req));
            chk("busy_level", 64'(busy), 64'(exp_busy));
            if (l2_req && !l2_req_q) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 64'(l2_req), 64'(0));
                end else begin
                    e = gq.pop_front();
                    chk("grant_cycle", 64'(cyc), 64'(e.cyc));
                    chk("l2_addr", 64'(l2_addr), e.val);
                    chk("grant_id_wait", 64'(grant_id), 64'(e.id));
                end
            end else if (gq.size() != 0 && gq[0].cyc < cyc) begin
                e = gq.pop_front();
                chk("missing_grant", 64'(l2_addr), e.val);
            end
            l2_req_q = l2_req;
            if (req_done != '0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'(req_done), 64'(0));
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("req_done", 64'(req_done), 64'(1) << e.id);
                    chk("req_data", req_data, e.val);
                    chk("grant_id_resp", 64'(grant_id), 64'(e.id));
                end
            end else if (dq.size() != 0 && dq[0].cyc < cyc) begin
                e = dq.pop_front();
                chk("missing_done", 64'(req_done), 64'(1) << e.id);
            end
        end
    end

    // Stimulus plus reference model: requesters, L2 responder, round-robin priority list.
    initial begin
        int              prio[$];
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] owner;
        logic [NREQ-1:0] sreq;
        logic [PAL-1:0]  addr [NREQ];
        logic            active;
        int              gnt;
        int              cnt;
        int              free_cyc;
        int              release_cyc;
        int              resp_cyc;
        int              quiet_until;
        int              late_done_cyc;
        ev_t             e;

        pending = '0; owner = '0; active = 1'b0; gnt = 0; cnt = 0;
        free_cyc = 0; release_cyc = -1; resp_cyc = -1; quiet_until = 0; late_done_cyc = -1;
        for (int i = 0; i < NREQ; i++) begin
            addr[i] = '0;
            prio.push_back(i);
        end

        reset = 1'b1; req = '0; req_addr = '0; l2_done = 1'b0; l2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l2_req", 64'(l2_req), 64'(0));
        chk("rst_l2_addr", 64'(l2_addr), 64'(0));
        chk("rst_req_done", 64'(req_done), 64'(0));
        chk("rst_req_data", req_data, 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            cyc++;
            sreq = req;
            #1;
            l2_done = 1'b0;
            reset   = 1'b0;

            if (!active && cyc >= free_cyc && sreq != '0) begin
                gnt = -1;
                foreach (prio[k]) begin
                    if (gnt < 0 && sreq[prio[k]]) gnt = prio[k];
                end
                while (prio[prio.size()-1] != gnt) prio.push_back(prio.pop_front());
                e.cyc = cyc; e.id = gnt; e.val = 64'(addr[gnt]);
                gq.push_back(e);
                owner[gnt] = 1'b1;
                active = 1'b1;
                cnt = $urandom_range(0, 3);
            end

            exp_l2req = active;
            exp_busy  = active || (cyc == resp_cyc);

            if (active && cnt >= 1 && $urandom_range(0, 24) == 0) begin
                // Abort the fetch with reset; its late completion arrives while idle.
                reset = 1'b1;
                active = 1'b0;
                pending = '0;
                owner = '0;
                prio.delete();
                for (int i = 0; i < NREQ; i++) prio.push_back(i);
                free_cyc = cyc + 2;
                quiet_until = cyc + 3;
                late_done_cyc = cyc + 2;
            end else if (active) begin
                if (cnt == 0) begin
                    l2_done = 1'b1;
                    l2_data = {$urandom, $urandom};
                    e.cyc = cyc + 1; e.id = gnt; e.val = l2_data;
                    dq.push_back(e);
                    active = 1'b0;
                    free_cyc = cyc + 3;
                    release_cyc = cyc + 2;
                    resp_cyc = cyc + 1;
                end else begin
                    cnt--;
                    if (pending[gnt] && $urandom_range(0, 5) == 0) pending[gnt] = 1'b0;
                end
            end else if (cyc == late_done_cyc || $urandom_range(0, 7) == 0) begin
                l2_done = 1'b1;
                l2_data = {$urandom, $urandom};
            end

            if (cyc == release_cyc) begin
                pending[gnt] = 1'b0;
                owner[gnt] = 1'b0;
            end

            for (int i = 0; i < NREQ; i++) begin
                if (it < 2980 && !pending[i] && !owner[i] && cyc >= quiet_until &&
                    (cyc == 1 || $urandom_range(0, 2) == 0)) begin
                    pending[i] = 1'b1;
                    addr[i] = {24'(i + 1), 32'($urandom)};
                end
                req_addr[i*PAL +: PAL] = addr[i];
            end
            req = pending;
        end

        #1;
        mon_en = 1'b0;
        @(negedge clk);
        chk("grant_queue_drained", 64'(gq.size()), 64'(0));
        chk("done_queue_drained", 64'(dq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
